// File: rtl/ballot_collector.sv
// -----------------------------------------------------------------------------
// ballot_collector
//
// Feeder for the 4-input minority-vote stage. Gathers one vote bit from each
// of four voters over a shared valid/ready channel (any arrival order),
// assembles them into a 4-bit ballot and holds it with a valid/ack handshake.
// A repeated vote from a voter already seen is accepted but discarded, and
// flagged with a one-cycle pulse.
//
// Optional feature (macro BALLOT_TIMEOUT_EN): an 8-bit counter limits the
// time spent collecting; when it expires a partial ballot is presented with
// timed_out set. Without the macro the collector waits indefinitely and
// timed_out is tied low.
//
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   vote_valid   in   vote present on vote/vote_id
//   vote_id[1:0] in   voter index, selects the ballot bit
//   vote         in   vote value
//   vote_ready   out  collector can accept a vote
//   ballot[3:0]  out  assembled ballot, bit i = voter i
//   ballot_valid out  ballot complete and stable
//   ballot_ack   in   consumer has taken the ballot
//   seen[3:0]    out  voters received in the current ballot
//   dup_err      out  one-cycle pulse after a duplicate vote was accepted
//   timed_out    out  presented ballot was forced by the timeout
// -----------------------------------------------------------------------------
module ballot_collector #(
   parameter int unsigned TIMEOUT = 32'd16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       vote_valid,
   input  logic [1:0] vote_id,
   input  logic       vote,
   output logic       vote_ready,
   output logic [3:0] ballot,
   output logic       ballot_valid,
   input  logic       ballot_ack,
   output logic [3:0] seen,
   output logic       dup_err,
   output logic       timed_out
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_PRESENT = 2'd2
   } state_t;

   state_t     state_r;
   state_t     state_nxt_s;
   logic [3:0] ballot_r;
   logic [3:0] ballot_nxt_s;
   logic [3:0] seen_r;
   logic [3:0] seen_nxt_s;
   logic       timed_out_r;
   logic       timed_out_nxt_s;
   logic       vote_ready_r;
   logic       ballot_valid_r;
   logic       dup_err_r;
   logic       accept_s;
   logic       dup_s;
   logic [3:0] id_mask_s;

`ifdef BALLOT_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 32'd1);
   logic [7:0] tmo_cnt_r;
   logic [7:0] tmo_cnt_nxt_s;
   logic       tmo_fire_s;
`endif

   // Decode a voter index into its ballot bit position.
   function automatic logic [3:0] id_onehot(input logic [1:0] id);
      logic [3:0] mask;
      mask = 4'b0000;
      mask[id] = 1'b1;
      return mask;
   endfunction

   // Handshake decode: vote_ready is a register, so acceptance has no
   // combinational dependence on anything but the current vote_valid.
   always_comb begin
      id_mask_s = id_onehot(vote_id);
      accept_s  = vote_valid & vote_ready_r;
      dup_s     = accept_s & ((seen_r & id_mask_s) != 4'b0000);
`ifdef BALLOT_TIMEOUT_EN
      tmo_fire_s = (tmo_cnt_r == TMO_LAST);
`endif
   end

   // Next-state and next-ballot logic.
   always_comb begin
      state_nxt_s     = state_r;
      ballot_nxt_s    = ballot_r;
      seen_nxt_s      = seen_r;
      timed_out_nxt_s = timed_out_r;
`ifdef BALLOT_TIMEOUT_EN
      tmo_cnt_nxt_s   = tmo_cnt_r;
`endif
      // First vote wins: a duplicate leaves ballot and seen untouched.
      if (accept_s && !dup_s) begin
         ballot_nxt_s = (ballot_r & ~id_mask_s) | (vote ? id_mask_s : 4'b0000);
         seen_nxt_s   = seen_r | id_mask_s;
      end else begin
         ballot_nxt_s = ballot_r;
         seen_nxt_s   = seen_r;
      end
      case (state_r)
         ST_IDLE: begin
            // One vote can never complete a ballot, so IDLE only moves on.
            if (accept_s) begin
               state_nxt_s = ST_COLLECT;
`ifdef BALLOT_TIMEOUT_EN
               tmo_cnt_nxt_s = 8'd0;
`endif
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            // Completion is checked first so that it beats a simultaneous
            // timeout.
            if (seen_nxt_s == 4'b1111) begin
               state_nxt_s     = ST_PRESENT;
               timed_out_nxt_s = 1'b0;
`ifdef BALLOT_TIMEOUT_EN
            end else if (tmo_fire_s) begin
               state_nxt_s     = ST_PRESENT;
               timed_out_nxt_s = 1'b1;
`endif
            end else begin
               state_nxt_s = ST_COLLECT;
`ifdef BALLOT_TIMEOUT_EN
               tmo_cnt_nxt_s = tmo_cnt_r + 8'd1;
`endif
            end
         end
         ST_PRESENT: begin
            if (ballot_ack) begin
               state_nxt_s     = ST_IDLE;
               ballot_nxt_s    = 4'b0000;
               seen_nxt_s      = 4'b0000;
               timed_out_nxt_s = 1'b0;
            end else begin
               state_nxt_s = ST_PRESENT;
            end
         end
         default: begin
            state_nxt_s     = ST_IDLE;
            ballot_nxt_s    = 4'b0000;
            seen_nxt_s      = 4'b0000;
            timed_out_nxt_s = 1'b0;
         end
      endcase
   end

   // State, ballot and registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r        <= ST_IDLE;
         ballot_r       <= 4'b0000;
         seen_r         <= 4'b0000;
         timed_out_r    <= 1'b0;
         vote_ready_r   <= 1'b1;
         ballot_valid_r <= 1'b0;
         dup_err_r      <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
         tmo_cnt_r      <= 8'd0;
`endif
      end else begin
         state_r        <= state_nxt_s;
         ballot_r       <= ballot_nxt_s;
         seen_r         <= seen_nxt_s;
         timed_out_r    <= timed_out_nxt_s;
         // Handshake flags are pre-decoded from the next state so they are
         // plain flops that track the state register exactly.
         vote_ready_r   <= (state_nxt_s != ST_PRESENT);
         ballot_valid_r <= (state_nxt_s == ST_PRESENT);
         dup_err_r      <= dup_s;
`ifdef BALLOT_TIMEOUT_EN
         tmo_cnt_r      <= tmo_cnt_nxt_s;
`endif
      end
   end

   assign vote_ready   = vote_ready_r;
   assign ballot       = ballot_r;
   assign ballot_valid = ballot_valid_r;
   assign seen         = seen_r;
   assign dup_err      = dup_err_r;
   assign timed_out    = timed_out_r;

endmodule

// File: tb/tb_ballot_collector.sv
// -----------------------------------------------------------------------------
// Testbench for ballot_collector: directed sequences followed by random
// traffic, checked against a voter-set reference model. Completed ballots are
// queued by the model and popped by an independent monitor when the DUT
// raises ballot_valid.
// -----------------------------------------------------------------------------
module tb_ballot_collector;
   localparam int TIMEOUT = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       vote_valid = 1'b0;
   logic [1:0] vote_id = 2'd0;
   logic       vote = 1'b0;
   logic       ballot_ack = 1'b0;
   logic       vote_ready;
   logic [3:0] ballot;
   logic       ballot_valid;
   logic [3:0] seen;
   logic       dup_err;
   logic       timed_out;

   ballot_collector #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n), .vote_valid(vote_valid), .vote_id(vote_id),
      .vote(vote), .vote_ready(vote_ready), .ballot(ballot),
      .ballot_valid(ballot_valid), .ballot_ack(ballot_ack), .seen(seen),
      .dup_err(dup_err), .timed_out(timed_out)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: which voters have been heard, their first votes,
   // whether a ballot is on offer, and edges elapsed since the first vote.
   logic [3:0] m_ballot = 4'd0;
   logic [3:0] m_seen = 4'd0;
   logic       m_present = 1'b0;
   logic       m_to = 1'b0;
   logic       m_dup = 1'b0;
   int         m_age = 0;
   logic [4:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ballot = 4'd0; m_seen = 4'd0; m_present = 1'b0;
      m_to = 1'b0; m_dup = 1'b0; m_age = 0;
      exp_q.delete();
   endtask

   // Apply the current inputs to the model as one clock edge.
   task automatic model_edge();
      logic was_collecting;
      m_dup = 1'b0;
      if (m_present) begin
         if (ballot_ack) begin
            m_present = 1'b0; m_seen = 4'd0; m_ballot = 4'd0; m_to = 1'b0;
         end
      end else begin
         was_collecting = (m_seen != 4'd0);
         if (was_collecting) m_age++;
         else m_age = 0;
         if (vote_valid) begin
            if (m_seen[vote_id]) m_dup = 1'b1;
            else begin
               m_seen[vote_id] = 1'b1;
               m_ballot[vote_id] = vote;
            end
         end
         if (m_seen == 4'hF) begin
            m_present = 1'b1; m_to = 1'b0;
            exp_q.push_back({1'b0, m_ballot});
         end
`ifdef BALLOT_TIMEOUT_EN
         else if (was_collecting && m_age == TIMEOUT) begin
            m_present = 1'b1; m_to = 1'b1;
            exp_q.push_back({1'b1, m_ballot});
         end
`endif
      end
   endtask

   // One clock cycle of stimulus: drive away from the edge, model the edge.
   task automatic cyc(input logic vv, input logic [1:0] id, input logic v, input logic ack);
      @(negedge clk);
      vote_valid = vv; vote_id = id; vote = v; ballot_ack = ack;
      @(posedge clk);
      model_edge();
   endtask

   task automatic idle(input int n, input logic ack);
      for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 1'b0, ack);
   endtask

   // Short asynchronous reset pulse between clock edges.
   task automatic async_reset();
      @(negedge clk);
      vote_valid = 1'b0; ballot_ack = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("rst_vote_ready", vote_ready, 1'b1);
      check("rst_ballot_valid", ballot_valid, 1'b0);
      check("rst_ballot", ballot, 4'd0);
      check("rst_seen", seen, 4'd0);
      check("rst_dup_err", dup_err, 1'b0);
      check("rst_timed_out", timed_out, 1'b0);
      model_reset();
      #1 rst_n = 1'b1;
      @(posedge clk);
      model_edge();
   endtask

   // Monitor: per-cycle output checks plus scoreboard pop on ballot_valid rise.
   initial begin : monitor
      logic prev_valid;
      logic [4:0] e;
      prev_valid = 1'b0;
      forever begin
         @(negedge clk);
         check("vote_ready", vote_ready, !m_present);
         check("ballot_valid", ballot_valid, m_present);
         check("seen", seen, m_seen);
         check("ballot", ballot, m_ballot);
         check("dup_err", dup_err, m_dup);
         check("timed_out", timed_out, m_to);
         if (ballot_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_unexpected: ballot %b presented with none expected", ballot);
            end else begin
               e = exp_q.pop_front();
               check("sb_ballot", ballot, e[3:0]);
               check("sb_timed_out", timed_out, e[4]);
            end
         end
         prev_valid = ballot_valid;
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // In-order ballot held until ack.
      cyc(1'b1, 2'd0, 1'b1, 1'b0);
      cyc(1'b1, 2'd1, 1'b0, 1'b0);
      cyc(1'b1, 2'd2, 1'b0, 1'b0);
      cyc(1'b1, 2'd3, 1'b0, 1'b0);
      idle(3, 1'b0);
      idle(1, 1'b1);
      idle(2, 1'b0);

      // Out-of-order ballot.
      cyc(1'b1, 2'd3, 1'b1, 1'b0);
      cyc(1'b1, 2'd0, 1'b1, 1'b0);
      cyc(1'b1, 2'd2, 1'b0, 1'b0);
      cyc(1'b1, 2'd1, 1'b1, 1'b0);
      idle(2, 1'b1);

      // Duplicate vote: first vote wins.
      cyc(1'b1, 2'd2, 1'b1, 1'b0);
      cyc(1'b1, 2'd2, 1'b0, 1'b0);
      idle(1, 1'b0);
      cyc(1'b1, 2'd0, 1'b0, 1'b0);
      cyc(1'b1, 2'd1, 1'b0, 1'b0);
      cyc(1'b1, 2'd3, 1'b0, 1'b0);
      idle(1, 1'b0);

      // Vote held during PRESENT, ack on same edge, accepted after.
      cyc(1'b1, 2'd0, 1'b1, 1'b0);
      cyc(1'b1, 2'd0, 1'b1, 1'b1);
      cyc(1'b1, 2'd0, 1'b1, 1'b0);
      idle(1, 1'b0);
      cyc(1'b1, 2'd1, 1'b1, 1'b0);
      cyc(1'b1, 2'd2, 1'b1, 1'b0);
      cyc(1'b1, 2'd3, 1'b0, 1'b0);
      idle(2, 1'b1);

`ifdef BALLOT_TIMEOUT_EN
      // Partial ballot forced out by the timeout.
      cyc(1'b1, 2'd0, 1'b1, 1'b0);
      cyc(1'b1, 2'd1, 1'b1, 1'b0);
      idle(20, 1'b0);
      idle(2, 1'b1);
      // Fourth vote on the firing edge: completion wins.
      cyc(1'b1, 2'd0, 1'b0, 1'b0);
      cyc(1'b1, 2'd1, 1'b1, 1'b0);
      cyc(1'b1, 2'd2, 1'b1, 1'b0);
      idle(13, 1'b0);
      cyc(1'b1, 2'd3, 1'b0, 1'b0);
      idle(2, 1'b0);
      idle(2, 1'b1);
`endif

      // Mid-ballot asynchronous reset, then a fresh ballot.
      cyc(1'b1, 2'd0, 1'b1, 1'b0);
      cyc(1'b1, 2'd3, 1'b1, 1'b0);
      async_reset();
      cyc(1'b1, 2'd1, 1'b0, 1'b0);
      cyc(1'b1, 2'd2, 1'b1, 1'b0);
      cyc(1'b1, 2'd0, 1'b0, 1'b0);
      cyc(1'b1, 2'd3, 1'b0, 1'b0);
      idle(2, 1'b1);

      // Random traffic with occasional resets.
      for (int i = 0; i < 1500; i++) begin
         if (i % 500 == 250) async_reset();
         cyc($urandom_range(0, 99) < 60, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom_range(0, 99) < 40);
      end

      idle(3, 1'b1);
      idle(1, 1'b0);
      check("sb_drain", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ballot_collector.md
# ballot_collector

Upstream feeder for the 4-input minority-vote stage. Collects one vote bit from each of four voters over a shared valid/ready channel in any order, assembles them into a 4-bit ballot, and presents it with a valid/ack handshake. BALLOT drives the minority stage's 4-bit input directly. Duplicate votes are flagged. An optional timeout releases a partial ballot.

## Interface
- TIMEOUT, 16: cycles allowed in COLLECT before a partial ballot is forced out (range 2..255); used only with the timeout feature.
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous, active-low reset
- VOTE_VALID  input  1  vote present on VOTE/VOTE_ID
- VOTE_ID  input  2  voter index 0..3, selects the BALLOT bit
- VOTE  input  1  vote value
- VOTE_READY  output  1  collector can accept a vote
- BALLOT  output  4  assembled ballot; bit i = voter i
- BALLOT_VALID  output  1  BALLOT complete and stable
- BALLOT_ACK  input  1  consumer has taken the ballot
- SEEN  output  4  mask of voters received in the current ballot
- DUP_ERR  output  1  one-cycle pulse: a duplicate vote was accepted
- TIMED_OUT  output  1  presented ballot was forced by timeout

## Operation
- Transfer: a vote is accepted on a rising CLK edge when VOTE_VALID=1 and VOTE_READY=1.
- States:
  - IDLE: SEEN=0000, VOTE_READY=1, BALLOT_VALID=0.
  - COLLECT: at least one vote received, VOTE_READY=1.
  - PRESENT: BALLOT_VALID=1, VOTE_READY=0.
- Transitions:
  - IDLE→COLLECT: on the first accepted vote.
  - COLLECT→PRESENT: when SEEN becomes 1111.
  - PRESENT→IDLE: on an edge with BALLOT_ACK=1.
- A single accepted vote into IDLE cannot complete a ballot; four distinct IDs are needed.
- Accepted vote with SEEN[id]=0:
  - BALLOT[id] ← VOTE
  - SEEN[id] ← 1
- Accepted vote with SEEN[id]=1 (duplicate):
  - BALLOT and SEEN are unchanged; the first vote wins.
  - DUP_ERR=1 for exactly the next cycle.
  - The state does not advance.
- PRESENT→IDLE clears BALLOT to 0000 and SEEN to 0000.
- BALLOT, SEEN and TIMED_OUT are held stable throughout PRESENT.
- BALLOT_ACK is ignored outside PRESENT.
- VOTE_VALID held in PRESENT is not accepted, because VOTE_READY=0. It is accepted on the first edge back in IDLE.
- Reset (asynchronous, any state, mid-ballot):
  - State → IDLE.
  - BALLOT=0000, SEEN=0000, BALLOT_VALID=0, DUP_ERR=0, TIMED_OUT=0, VOTE_READY=1 (while reset is low and after it releases).
  - Timeout counter = 0.
  - Partial ballots are discarded.

## Timing
- BALLOT_VALID rises in the cycle after the edge that accepts the fourth distinct vote. Minimum ballot latency is 4 accepted-vote edges.
- BALLOT_VALID falls in the cycle after the BALLOT_ACK edge. VOTE_READY rises in the same cycle.
- Ballot-to-ballot throughput: 4 vote cycles + 1 present cycle (ACK tied high) = 5 cycles per ballot.
- SEEN and BALLOT bits update in the cycle after each accepting edge.
- All outputs are registered. VOTE_READY is decoded from state only, with no input→output combinational path.

## Configuration
- Macro: BALLOT_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on IDLE→COLLECT and increments each cycle in COLLECT.
  - The counter reaching TIMEOUT-1 without completion forces COLLECT→PRESENT. Missing BALLOT bits stay 0 and TIMED_OUT=1.
  - TIMED_OUT is held until the ack, then cleared.
  - If the completing fourth vote is accepted on the same edge the timeout fires, completion wins and TIMED_OUT=0.
- Undefined:
  - No counter; COLLECT waits indefinitely.
  - TIMED_OUT is tied to 0 and TIMEOUT is unused.

## Test plan
- Reset, then votes (id,v) = (0,1), (1,0), (2,0), (3,0) on consecutive edges, ACK=0 → next cycle BALLOT=0001, BALLOT_VALID=1, SEEN=1111, VOTE_READY=0. The ballot holds until ACK; the cycle after ACK shows BALLOT=0000, BALLOT_VALID=0.
- Out-of-order votes (3,1), (0,1), (2,0), (1,1) → BALLOT=1011, valid one cycle after the fourth vote.
- Votes (2,1), (2,0) → second edge pulses DUP_ERR for one cycle; BALLOT[2] stays 1 and SEEN=0100. Completing with ids 0, 1, 3 at 0 gives BALLOT=0100.
- VOTE_VALID held high in PRESENT with ACK asserted on the same edge → the vote is not accepted on that edge, and is accepted on the next edge into IDLE.
- With BALLOT_TIMEOUT_EN and TIMEOUT=16: votes (0,1), (1,1) then idle → the forced ballot presents BALLOT=0011, SEEN=0011, TIMED_OUT=1. A variant with the fourth vote on the firing edge gives TIMED_OUT=0.
- Drop RST_N for one half-cycle after two votes → all outputs reset immediately (asynchronously). The next four votes form a fresh ballot with no stale bits.
